// File: rtl/register_file_pkg.sv
// Shared sizing and types for the datapath register file.
// Decode, datapath and bench all take their widths from here.
package register_file_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 2;
  localparam int unsigned REG_COUNT          = 2 ** DEFAULT_ADDR_WIDTH;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/register_file_if.sv
// Register file access bus: two read indices, one write port sharing index A.
// The master is the core's decode/result path; the slave is the register file.
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] address_a;
  logic [ADDR_WIDTH-1:0] address_b;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;

  modport master (
    output address_a,
    output address_b,
    output write_enable,
    output write_data,
    input  data_a,
    input  data_b
  );

  modport slave (
    input  address_a,
    input  address_b,
    input  write_enable,
    input  write_data,
    output data_a,
    output data_b
  );

endinterface

// File: rtl/register_file.sv
// Multi-ported register file: two combinational read ports, one synchronous
// write port addressed by read index A. Asynchronous active-high reset.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned           ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input logic           clk,
  input logic           reset,
  register_file_if.slave bus
);

  localparam int unsigned RegCount = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [RegCount];
  logic [DATA_WIDTH-1:0] regs_d [RegCount];

  // Only the entry at address_a may change; all others hold.
  always_comb begin
    for (int i = 0; i < RegCount; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (bus.write_enable) begin
      regs_d[bus.address_a] = bus.write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RegCount; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < RegCount; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // No write-through bypass: reads see the old value until the write edge.
  always_comb begin
    bus.data_a = regs_q[bus.address_a];
    bus.data_b = regs_q[bus.address_b];
  end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;
  import register_file_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  register_file_if #(
    .DATA_WIDTH(DEFAULT_DATA_WIDTH),
    .ADDR_WIDTH(DEFAULT_ADDR_WIDTH)
  ) bus ();

  register_file #(
    .DATA_WIDTH (DEFAULT_DATA_WIDTH),
    .ADDR_WIDTH (DEFAULT_ADDR_WIDTH),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish first");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    bus.write_enable = 1'b0;
    bus.write_data   = 8'h00;
    bus.address_a    = '0;
    bus.address_b    = '0;
    #1;
    for (int i = 0; i < REG_COUNT; i++) begin
      bus.address_a = reg_idx_t'(i);
      bus.address_b = reg_idx_t'(i);
      #1;
      checks++;
      if (bus.data_a !== 8'h00) begin
        failures++;
        $display("FAIL reset_a[%0d]: got %h, required 00", i, bus.data_a);
      end
      checks++;
      if (bus.data_b !== 8'h00) begin
        failures++;
        $display("FAIL reset_b[%0d]: got %h, required 00", i, bus.data_b);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    reg_data_t exp;
    bus.address_a    = 2'd2;
    bus.write_data   = 8'hAA;
    bus.write_enable = 1'b1;
    tick();
    bus.write_enable = 1'b0;
    bus.address_b    = 2'd2;
    #1;
    checks++;
    if (bus.data_a !== 8'hAA) begin
      failures++;
      $display("FAIL write_read_a: got %h, required aa", bus.data_a);
    end
    checks++;
    if (bus.data_b !== 8'hAA) begin
      failures++;
      $display("FAIL write_read_b: got %h, required aa", bus.data_b);
    end
    for (int i = 0; i < REG_COUNT; i++) begin
      exp = (i == 2) ? 8'hAA : 8'h00;
      bus.address_a = reg_idx_t'(i);
      bus.address_b = reg_idx_t'(REG_COUNT - 1 - i);
      #1;
      checks++;
      if (bus.data_a !== exp) begin
        failures++;
        $display("FAIL write_read_others[%0d]: got %h, required %h", i, bus.data_a, exp);
      end
    end
  endtask

  task automatic test_write_disabled();
    bus.address_a    = 2'd1;
    bus.address_b    = 2'd1;
    bus.write_data   = 8'h55;
    bus.write_enable = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.data_a !== 8'h00) begin
      failures++;
      $display("FAIL write_disabled_a: got %h, required 00", bus.data_a);
    end
    checks++;
    if (bus.data_b !== 8'h00) begin
      failures++;
      $display("FAIL write_disabled_b: got %h, required 00", bus.data_b);
    end
  endtask

  task automatic test_async_reset();
    bus.write_enable = 1'b1;
    bus.write_data   = 8'hAA;
    for (int i = 0; i < REG_COUNT; i++) begin
      bus.address_a = reg_idx_t'(i);
      tick();
    end
    bus.write_enable = 1'b0;
    bus.address_a    = 2'd0;
    bus.address_b    = 2'd3;
    #1;
    checks++;
    if (bus.data_b !== 8'hAA) begin
      failures++;
      $display("FAIL async_reset_preload: got %h, required aa", bus.data_b);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < REG_COUNT; i++) begin
      bus.address_a = reg_idx_t'(i);
      bus.address_b = reg_idx_t'(i);
      #0.1;
      checks++;
      if (bus.data_a !== 8'h00 || bus.data_b !== 8'h00) begin
        failures++;
        $display("FAIL async_reset[%0d]: got a=%h b=%h, required 00 00", i, bus.data_a,
                 bus.data_b);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_dual_read();
    reg_data_t vals [REG_COUNT];
    vals[0] = 8'h11;
    vals[1] = 8'h22;
    vals[2] = 8'h33;
    vals[3] = 8'h44;
    bus.write_enable = 1'b1;
    for (int i = 0; i < REG_COUNT; i++) begin
      bus.address_a  = reg_idx_t'(i);
      bus.write_data = vals[i];
      tick();
    end
    bus.write_enable = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) begin
      bus.address_a = reg_idx_t'(i);
      bus.address_b = reg_idx_t'(REG_COUNT - 1 - i);
      #1;
      checks++;
      if (bus.data_a !== vals[i]) begin
        failures++;
        $display("FAIL dual_read_a[%0d]: got %h, required %h", i, bus.data_a, vals[i]);
      end
      checks++;
      if (bus.data_b !== vals[REG_COUNT-1-i]) begin
        failures++;
        $display("FAIL dual_read_b[%0d]: got %h, required %h", REG_COUNT - 1 - i, bus.data_b,
                 vals[REG_COUNT-1-i]);
      end
    end
  endtask

  task automatic test_read_during_write();
    @(negedge clk);
    bus.address_a    = 2'd3;
    bus.address_b    = 2'd3;
    bus.write_data   = 8'h99;
    bus.write_enable = 1'b1;
    #1;
    checks++;
    if (bus.data_a !== 8'h44 || bus.data_b !== 8'h44) begin
      failures++;
      $display("FAIL rdw_before: got a=%h b=%h, required 44 44", bus.data_a, bus.data_b);
    end
    tick();
    checks++;
    if (bus.data_a !== 8'h99 || bus.data_b !== 8'h99) begin
      failures++;
      $display("FAIL rdw_after: got a=%h b=%h, required 99 99", bus.data_a, bus.data_b);
    end
    // Reset raised on the same edge as an enabled write must win.
    @(negedge clk);
    bus.write_data = 8'h77;
    @(posedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.data_a !== 8'h00) begin
      failures++;
      $display("FAIL rdw_reset_wins: got %h, required 00", bus.data_a);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks++;
    if (bus.data_a !== 8'h77) begin
      failures++;
      $display("FAIL write_after_reset: got %h, required 77", bus.data_a);
    end
    bus.write_enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.address_a    = 2'd0;
    bus.address_b    = 2'd0;
    bus.write_enable = 1'b1;
    bus.write_data   = 8'h01;
    tick();
    checks++;
    if (bus.data_a !== 8'h01) begin
      failures++;
      $display("FAIL b2b_first: got %h, required 01", bus.data_a);
    end
    bus.write_data = 8'h02;
    tick();
    checks++;
    if (bus.data_b !== 8'h02) begin
      failures++;
      $display("FAIL b2b_second: got %h, required 02", bus.data_b);
    end
    bus.write_enable = 1'b0;
    bus.address_b    = 2'd3;
    #1;
    checks++;
    if (bus.data_b !== 8'h77) begin
      failures++;
      $display("FAIL b2b_other_hold: got %h, required 77", bus.data_b);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_write_read();
    test_write_disabled();
    test_async_reset();
    test_dual_read();
    test_read_during_write();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
